// File: rtl/pipe_pkg.sv
// Shared pipeline package: per-stage payload structs and pipeline-wide constants.
// Stage registers carry these structs as opaque packed vectors (DATA_BITS=$bits(<stage>_t));
// the halt flag travels beside the payload, not inside it.
package pipe_pkg;

  localparam int PIPE_SKID_DEPTH = 2;
  localparam int PIPE_CNT_BITS   = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        atomic;
    logic        sel_mem;
    logic        check_link;
    logic        mem_rw_;
    logic        rw_;
    logic [4:0]  waddr;
    logic        load_link_;
    logic [31:0] r1_data;
    logic [31:0] r2_data;
    logic        alu_imm;
    logic [31:0] sign_ext_imm;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic [3:0]  byte_en;
  } id_ex_t;

  typedef struct packed {
    logic        sel_mem;
    logic        mem_rw_;
    logic        rw_;
    logic [4:0]  waddr;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [3:0]  byte_en;
  } ex_mem_t;

  typedef struct packed {
    logic        rw_;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_mem.sv
// Entry storage for the skid stage: DEPTH entries of {halt, payload}.
// Control (count, pointers, flush, halt tracking) lives in the parent.
module pipe_skid_mem #(
  parameter int DATA_BITS = 128,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_ptr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_halt,
  input  logic                 rd_ptr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_halt
);

  logic [DATA_BITS:0] mem [DEPTH];

  // Write one entry at the tail pointer; reset clears every entry so out_data reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= {wr_halt, wr_data};
    end
  end

  assign {rd_halt, rd_data} = mem[rd_ptr];

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 1- or 2-entry skid
// buffer, synchronous flush and sticky halt capture.
// Optional macro PIPE_STAGE_STALL_CNT_EN adds a saturating stall_cycles counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_BITS = 128,
  parameter int DEPTH     = PIPE_SKID_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic                     in_halt,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITS-1:0]     out_data,
  output logic                     out_halt,
  output logic [1:0]               occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [PIPE_CNT_BITS-1:0] stall_cycles
`endif
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [1:0] count;
  logic       head;
  logic       tail;
  logic       halt_seen;
  logic       accept;
  logic       issue;

  // Pointers wrap naturally as 1-bit values; a single-entry stage keeps them at 0.
  function automatic logic ptr_next(input logic p);
    return (DEPTH == 2) ? ~p : 1'b0;
  endfunction

  // Handshake is derived from registers only, so out_ready never reaches in_ready.
  assign in_ready  = (count != FULL_CNT) & ~halt_seen;
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;
  assign occupancy = count;

  // Occupancy, pointers and sticky halt; flush overrides accept/issue and drops the incoming payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      halt_seen <= 1'b0;
    end else if (flush) begin
      count     <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      if (accept) tail <= ptr_next(tail);
      if (issue)  head <= ptr_next(head);
      case ({accept, issue})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && in_halt) halt_seen <= 1'b1;
    end
  end

  pipe_skid_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept & ~flush),
    .wr_ptr  (tail),
    .wr_data (in_data),
    .wr_halt (in_halt),
    .rd_ptr  (head),
    .rd_data (out_data),
    .rd_halt (out_halt)
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  function automatic logic [PIPE_CNT_BITS-1:0] sat_inc(input logic [PIPE_CNT_BITS-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Count cycles where upstream offers a payload but is blocked; flush cycles are not stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (in_valid && !in_ready && !flush) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule
